// File: rtl/mem_data_arbiter.sv
// Two-requester arbiter and sequencer for OTTER memory port 2 (M0 = CPU load/store, M1 = DMA/debug).
// The access fields stay latched through the read-return cycle because the memory sizes and sign-extends read data combinationally.
module mem_data_arbiter #(
  parameter int FIXED_PRIO = 0,
  parameter int MAX_WAIT   = 4
) (
  input  logic        ARB_CLK,
  input  logic        ARB_RST_N,
  input  logic        M0_REQ,
  input  logic        M0_WE,
  input  logic [31:0] M0_ADDR,
  input  logic [31:0] M0_DIN,
  input  logic [1:0]  M0_SIZE,
  input  logic        M0_SIGN,
  output logic        M0_GNT,
  output logic        M0_RVALID,
  output logic [31:0] M0_DOUT,
  input  logic        M1_REQ,
  input  logic        M1_WE,
  input  logic [31:0] M1_ADDR,
  input  logic [31:0] M1_DIN,
  input  logic [1:0]  M1_SIZE,
  input  logic        M1_SIGN,
  output logic        M1_GNT,
  output logic        M1_RVALID,
  output logic [31:0] M1_DOUT,
  output logic        MEM_RDEN2,
  output logic        MEM_WE2,
  output logic [31:0] MEM_ADDR2,
  output logic [31:0] MEM_DIN2,
  output logic [1:0]  MEM_SIZE,
  output logic        MEM_SIGN,
  input  logic [31:0] MEM_DOUT2,
  output logic        ARB_BUSY
);

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t      state;
  logic        owner;
  logic        last;
  logic [3:0]  wait_cnt;
  logic        we_l;
  logic [31:0] addr_l;
  logic [31:0] din_l;
  logic [1:0]  size_l;
  logic        sign_l;
  logic        gnt0;
  logic        gnt1;
  logic        rvalid0;
  logic        rvalid1;
  logic        rden;
  logic        wen;

  logic        arb_point;
  logic        win;
  logic        win_we;
  logic [31:0] win_addr;
  logic [31:0] win_din;
  logic [1:0]  win_size;
  logic        win_sign;

  // Winner selection: win = 1 means M1 takes the next access.
  always_comb begin
    arb_point = (state == IDLE) || (state == RESP);
    if (M0_REQ && M1_REQ) begin
      if (FIXED_PRIO != 0) win = (wait_cnt == MAX_W);
      else                 win = ~last;
    end else begin
      win = M1_REQ;
    end
    win_we   = win ? M1_WE   : M0_WE;
    win_addr = win ? M1_ADDR : M0_ADDR;
    win_din  = win ? M1_DIN  : M0_DIN;
    win_size = win ? M1_SIZE : M0_SIZE;
    win_sign = win ? M1_SIGN : M0_SIGN;
  end

  always_ff @(posedge ARB_CLK) begin
    if (!ARB_RST_N) begin
      state    <= IDLE;
      owner    <= 1'b0;
      last     <= 1'b1;
      wait_cnt <= '0;
      we_l     <= 1'b0;
      addr_l   <= '0;
      din_l    <= '0;
      size_l   <= '0;
      sign_l   <= 1'b0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      rden     <= 1'b0;
      wen      <= 1'b0;
    end else begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rden    <= 1'b0;
      wen     <= 1'b0;
      if (arb_point) begin
        if (M0_REQ || M1_REQ) begin
          state  <= ISSUE;
          owner  <= win;
          last   <= win;
          we_l   <= win_we;
          addr_l <= win_addr;
          din_l  <= win_din;
          size_l <= win_size;
          sign_l <= win_sign;
          gnt0   <= ~win;
          gnt1   <= win;
          rden   <= ~win_we;
          wen    <= win_we;
          // Starvation counter only moves while M1 is actually contending.
          if (M1_REQ) begin
            if (win)                    wait_cnt <= '0;
            else if (wait_cnt != MAX_W) wait_cnt <= wait_cnt + 4'd1;
          end
        end else begin
          state <= IDLE;
        end
      end else begin
        state   <= we_l ? IDLE : RESP;
        rvalid0 <= ~we_l & ~owner;
        rvalid1 <= ~we_l & owner;
      end
    end
  end

  assign M0_GNT    = gnt0;
  assign M1_GNT    = gnt1;
  assign M0_RVALID = rvalid0;
  assign M1_RVALID = rvalid1;
  assign M0_DOUT   = rvalid0 ? MEM_DOUT2 : '0;
  assign M1_DOUT   = rvalid1 ? MEM_DOUT2 : '0;
  assign MEM_RDEN2 = rden;
  assign MEM_WE2   = wen;
  assign MEM_ADDR2 = addr_l;
  assign MEM_DIN2  = din_l;
  assign MEM_SIZE  = size_l;
  assign MEM_SIGN  = sign_l;
  assign ARB_BUSY  = (state != IDLE);

endmodule

// File: tb/tb_mem_data_arbiter.sv
// Bench for mem_data_arbiter: round-robin and fixed-priority instances share stimulus, each with its own memory.
// Expected grants and read returns are queued at issue time and consumed by a monitor.
module tb_mem_data_arbiter;

  localparam logic [31:0] IO_BASE = 32'h0001_0000;

  typedef struct packed {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] din;
    logic [1:0]  size;
    logic        sign;
  } gnt_t;

  typedef struct packed {
    logic        port;
    logic [31:0] addr;
    logic [31:0] data;
  } rd_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        m0_req = 1'b0, m0_we = 1'b0, m0_sign = 1'b0;
  logic [31:0] m0_addr = '0, m0_din = '0;
  logic [1:0]  m0_size = '0;
  logic        m1_req = 1'b0, m1_we = 1'b0, m1_sign = 1'b0;
  logic [31:0] m1_addr = '0, m1_din = '0;
  logic [1:0]  m1_size = '0;

  logic        gnt0 [2], gnt1 [2], rv0 [2], rv1 [2], rden [2], we2 [2], sign2 [2], busy [2];
  logic [31:0] dout0 [2], dout1 [2], addr2 [2], din2 [2], mem_dout [2], lat [2];
  logic [1:0]  size2 [2];
  logic [31:0] io_in;

  logic [7:0]  rmem [1024];
  logic [7:0]  emem [2][1024];
  bit          init_req = 1'b0;
  bit          mon_en = 1'b0;

  gnt_t gq [2][$];
  rd_t  rq [2][$];
  gnt_t mg;
  rd_t  mr;
  int   checks = 0;
  int   failures = 0;

  mem_data_arbiter #(.FIXED_PRIO(0), .MAX_WAIT(4)) u_rr (
    .ARB_CLK(clk), .ARB_RST_N(rst_n),
    .M0_REQ(m0_req), .M0_WE(m0_we), .M0_ADDR(m0_addr), .M0_DIN(m0_din), .M0_SIZE(m0_size), .M0_SIGN(m0_sign),
    .M0_GNT(gnt0[0]), .M0_RVALID(rv0[0]), .M0_DOUT(dout0[0]),
    .M1_REQ(m1_req), .M1_WE(m1_we), .M1_ADDR(m1_addr), .M1_DIN(m1_din), .M1_SIZE(m1_size), .M1_SIGN(m1_sign),
    .M1_GNT(gnt1[0]), .M1_RVALID(rv1[0]), .M1_DOUT(dout1[0]),
    .MEM_RDEN2(rden[0]), .MEM_WE2(we2[0]), .MEM_ADDR2(addr2[0]), .MEM_DIN2(din2[0]),
    .MEM_SIZE(size2[0]), .MEM_SIGN(sign2[0]), .MEM_DOUT2(mem_dout[0]), .ARB_BUSY(busy[0])
  );

  mem_data_arbiter #(.FIXED_PRIO(1), .MAX_WAIT(4)) u_fp (
    .ARB_CLK(clk), .ARB_RST_N(rst_n),
    .M0_REQ(m0_req), .M0_WE(m0_we), .M0_ADDR(m0_addr), .M0_DIN(m0_din), .M0_SIZE(m0_size), .M0_SIGN(m0_sign),
    .M0_GNT(gnt0[1]), .M0_RVALID(rv0[1]), .M0_DOUT(dout0[1]),
    .M1_REQ(m1_req), .M1_WE(m1_we), .M1_ADDR(m1_addr), .M1_DIN(m1_din), .M1_SIZE(m1_size), .M1_SIGN(m1_sign),
    .M1_GNT(gnt1[1]), .M1_RVALID(rv1[1]), .M1_DOUT(dout1[1]),
    .MEM_RDEN2(rden[1]), .MEM_WE2(we2[1]), .MEM_ADDR2(addr2[1]), .MEM_DIN2(din2[1]),
    .MEM_SIZE(size2[1]), .MEM_SIGN(sign2[1]), .MEM_DOUT2(mem_dout[1]), .ARB_BUSY(busy[1])
  );

  // Memory environment: word captured on RDEN2, sized/sign-extended from the live port fields.
  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                          input logic [1:0] sz, input logic sg);
    logic [31:0] s;
    s = w >> (8 * off);
    case (sz)
      2'd0:    return sg ? {24'd0, s[7:0]}  : {{24{s[7]}}, s[7:0]};
      2'd1:    return sg ? {16'd0, s[15:0]} : {{16{s[15]}}, s[15:0]};
      default: return s;
    endcase
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (init_req) begin
        for (int k = 0; k < 1024; k++) emem[i][k] <= rmem[k];
      end else if (we2[i] && addr2[i] < IO_BASE) begin
        for (int k = 0; k < 4; k++)
          if (k < (1 << size2[i])) emem[i][addr2[i][9:0] + 10'(k)] <= din2[i][8*k +: 8];
      end
      if (rden[i])
        lat[i] <= (addr2[i] >= IO_BASE) ? io_in :
                  {emem[i][{addr2[i][9:2], 2'd3}], emem[i][{addr2[i][9:2], 2'd2}],
                   emem[i][{addr2[i][9:2], 2'd1}], emem[i][{addr2[i][9:2], 2'd0}]};
    end
  end

  always @* begin
    for (int i = 0; i < 2; i++) mem_dout[i] = extract(lat[i], addr2[i][1:0], size2[i], sign2[i]);
  end

  // Reference memory: byte array read and written directly by access size.
  function automatic logic [31:0] ref_read(input logic [31:0] a, input logic [1:0] sz, input logic sg);
    logic [9:0]  i;
    logic [7:0]  b;
    logic [15:0] h;
    if (a >= IO_BASE) return io_in;
    i = a[9:0];
    b = rmem[i];
    h = {rmem[i + 10'd1], rmem[i]};
    case (sz)
      2'd0:    return sg ? {24'd0, b} : {{24{b[7]}}, b};
      2'd1:    return sg ? {16'd0, h} : {{16{h[15]}}, h};
      default: return {rmem[i + 10'd3], rmem[i + 10'd2], h};
    endcase
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    for (int k = 0; k < (1 << sz); k++) rmem[a[9:0] + 10'(k)] = d[8*k +: 8];
  endtask

  task automatic check(input string name, input int inst, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d actual=%0h required=%0h", name, inst, act, exp);
    end
  endtask

  task automatic drive(input logic p, input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] din, input logic [1:0] sz, input logic sg);
    if (p) begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_din = din; m1_size = sz; m1_sign = sg;
    end else begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_din = din; m0_size = sz; m0_sign = sg;
    end
  endtask

  task automatic reset_check(input string name);
    for (int i = 0; i < 2; i++)
      check(name, i, {gnt0[i], gnt1[i], rv0[i], rv1[i], rden[i], we2[i], busy[i],
                      dout0[i], dout1[i], addr2[i], din2[i], size2[i], sign2[i]}, '0);
  endtask

  // One uncontended access; expectations are identical for both instances.
  task automatic do_req(input logic p, input logic we, input logic [31:0] addr, input logic [31:0] din,
                        input logic [1:0] sz, input logic sg, input bit chk_lat, input bit want_rd);
    gnt_t g;
    rd_t  r;
    int   n;
    bit   got;
    g.port = p; g.we = we; g.addr = addr; g.din = din; g.size = sz; g.sign = sg;
    gq[0].push_back(g);
    gq[1].push_back(g);
    if (we) begin
      ref_write(addr, din, sz);
    end else if (want_rd) begin
      r.port = p; r.addr = addr; r.data = ref_read(addr, sz, sg);
      rq[0].push_back(r);
      rq[1].push_back(r);
    end
    drive(p, 1'b1, we, addr, din, sz, sg);
    got = 1'b0;
    n = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      got = p ? gnt1[0] : gnt0[0];
    end
    if (!got) check("gnt_timeout", p, 0, 1);
    else if (chk_lat) check("gnt_latency", p, n, 1);
    drive(p, 1'b0, we, addr, din, sz, sg);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    reset_check("reset_outputs");
    rst_n = 1'b1;
  endtask

  // Both requesters issue loads continuously; grant order comes from the policy alone.
  task automatic arb_run(input int nq);
    gnt_t g;
    rd_t  r;
    int   wc, n, seen;
    logic p;
    logic [31:0] d0, d1;
    d0 = $urandom;
    d1 = $urandom;
    wc = 0;
    for (int k = 0; k < nq; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (i == 0) p = 1'(k % 2);
        else if (wc == 4) begin p = 1'b1; wc = 0; end
        else begin p = 1'b0; wc++; end
        g.port = p; g.we = 1'b0; g.addr = p ? 32'h80 : 32'h40; g.din = p ? d1 : d0;
        g.size = 2'd2; g.sign = 1'b0;
        r.port = p; r.addr = g.addr; r.data = ref_read(g.addr, 2'd2, 1'b0);
        gq[i].push_back(g);
        rq[i].push_back(r);
      end
    end
    drive(1'b0, 1'b1, 1'b0, 32'h40, d0, 2'd2, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 32'h80, d1, 2'd2, 1'b0);
    n = 0;
    seen = 0;
    while (seen < nq && n < 4 * nq + 10) begin
      @(negedge clk);
      n++;
      if (gnt0[0] | gnt1[0]) seen++;
    end
    if (seen < nq) check("arb_timeout", 0, seen, nq);
    m0_req = 1'b0;
    m1_req = 1'b0;
  endtask

  // Monitor: every grant and read return is matched against the head of its queue.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 2; i++) begin
        if (gnt0[i] | gnt1[i]) begin
          if (gq[i].size() == 0) check("unexpected_gnt", i, {gnt1[i], gnt0[i]}, 0);
          else begin
            mg = gq[i].pop_front();
            check("grant", i,
                  {gnt1[i], gnt0[i], we2[i], rden[i], addr2[i], din2[i], size2[i], sign2[i], busy[i]},
                  {mg.port, ~mg.port, mg.we, ~mg.we, mg.addr, mg.din, mg.size, mg.sign, 1'b1});
          end
        end else begin
          check("mem_ctl_idle", i, {rden[i], we2[i]}, 0);
        end
        if (rv0[i] | rv1[i]) begin
          if (rq[i].size() == 0) check("unexpected_rvalid", i, {rv1[i], rv0[i]}, 0);
          else begin
            mr = rq[i].pop_front();
            check("read_return", i,
                  {rv1[i], rv0[i], mr.port ? dout1[i] : dout0[i], mr.port ? dout0[i] : dout1[i], addr2[i], busy[i]},
                  {mr.port, ~mr.port, mr.data, 32'd0, mr.addr, 1'b1});
          end
        end else begin
          check("dout_idle", i, {dout0[i], dout1[i]}, 0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    io_in = 32'h1234_5678;
    for (int k = 0; k < 1024; k++) rmem[k] = 8'($urandom);
    rmem[10'h100] = 8'hEF; rmem[10'h101] = 8'hBE; rmem[10'h102] = 8'hAD; rmem[10'h103] = 8'hDE;
    init_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    init_req = 1'b0;
    reset_check("reset_state");
    mon_en = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);

    do_req(1'b0, 1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    do_req(1'b1, 1'b1, 32'h203, 32'h0000_00A5, 2'd0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    do_req(1'b0, 1'b0, 32'h203, 32'h0, 2'd0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    do_req(1'b0, 1'b0, 32'h0001_1000, 32'h0, 2'd2, 1'b0, 1'b1, 1'b1);
    @(negedge clk);

    for (int t = 0; t < 40; t++) begin
      logic        p, we, sg;
      logic [1:0]  sz;
      logic [31:0] a;
      p  = 1'($urandom);
      we = 1'($urandom);
      sg = 1'($urandom);
      sz = 2'($urandom_range(0, 2));
      a  = {22'd0, 10'($urandom)} & ~((32'd1 << sz) - 32'd1);
      if (!we && $urandom_range(0, 7) == 0) begin
        a  = IO_BASE + {20'd0, 10'($urandom), 2'b00};
        sz = 2'd2;
      end
      do_req(p, we, a, $urandom, sz, sg, 1'b0, 1'b1);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    repeat (3) @(negedge clk);

    pulse_reset();
    @(negedge clk);
    arb_run(12);
    repeat (4) @(negedge clk);

    // Load aborted by reset during its ISSUE cycle: no read return may follow.
    do_req(1'b0, 1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 1'b0, 1'b0);
    pulse_reset();
    repeat (3) @(negedge clk);
    // Reset during RESP: the return in RESP stands, nothing follows it.
    do_req(1'b0, 1'b0, 32'h104, 32'h0, 2'd2, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    pulse_reset();
    repeat (3) @(negedge clk);
    // Store whose ISSUE cycle coincides with the reset edge still lands.
    do_req(1'b1, 1'b1, 32'h20, $urandom, 2'd2, 1'b0, 1'b0, 1'b1);
    pulse_reset();
    @(negedge clk);
    do_req(1'b0, 1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 1'b1, 1'b1);
    repeat (5) @(negedge clk);

    for (int i = 0; i < 2; i++) check("queue_drain", i, {gq[i].size(), rq[i].size()}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
